// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between the IFU and decode.
// It takes up to two packets per cycle and presents the two oldest to decode.
package fetch_queue_pkg;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] inst;
      logic [1:0]  bp_state;
      logic        bp_hit;
   } If_id_pkt_t;
endpackage

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  If_id_pkt_t [1:0]           fetch_pkt,
   input  logic                       flush,
   input  logic [1:0]                 dec_stall,
   output If_id_pkt_t [1:0]           if_id_pkt,
   output logic                       fq_stall,
   output logic [$clog2(DEPTH+1)-1:0] fq_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   If_id_pkt_t    mem_q [DEPTH];
   If_id_pkt_t    mem_d [DEPTH];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] head_p1, tail_p1;
   logic [CW-1:0] count_q, count_d;
   logic [CW:0]   count_sum;
   logic [1:0]    n_enq, n_deq;

   // Outputs depend only on registered state, never on this cycle's inputs.
   always_comb begin
      head_p1   = head_q + PW'(1);
      if_id_pkt = '0;
      if (count_q >= CW'(1)) if_id_pkt[0] = mem_q[head_q];
      if (count_q >= CW'(2)) if_id_pkt[1] = mem_q[head_p1];
   end

   assign fq_stall = (count_q > CW'(DEPTH - 2));
   assign fq_count = count_q;

   always_comb begin
      tail_p1 = tail_q + PW'(1);
      n_enq   = '0;
      if (!fq_stall && !flush)
         n_enq = {1'b0, fetch_pkt[0].valid} + {1'b0, fetch_pkt[1].valid};
      mem_d = mem_q;
      if (n_enq >= 2'd1) mem_d[tail_q]  = fetch_pkt[0];
      if (n_enq == 2'd2) mem_d[tail_p1] = fetch_pkt[1];
   end

   always_comb begin
      n_deq = '0;
      if (if_id_pkt[0].valid && !dec_stall[0])
         n_deq = (if_id_pkt[1].valid && !dec_stall[1]) ? 2'd2 : 2'd1;
   end

   // Flush overrides both enqueue and dequeue; storage is left as-is.
   always_comb begin
      count_sum = {1'b0, count_q} + (CW+1)'(n_enq) - (CW+1)'(n_deq);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(n_deq);
         tail_d  = tail_q + PW'(n_enq);
         count_d = count_sum[CW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

   // An underflow wraps count_sum to a large value, so one bound covers both cases.
   always @(posedge clk) begin
      if (!rst && !flush)
         assert (count_sum <= (CW+1)'(DEPTH));
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch unit (IFU) and `decode`. It accepts up to two fetched instructions per cycle as `If_id_pkt_t` packets, holds them in a circular FIFO, and presents the oldest two to `decode` as `if_id_pkt`. Decode consumes packets in order, and a front-end flush (mispredict or exception redirect) empties the queue.

## Interface

Parameters:
- `DEPTH`, default 8: number of packet entries. Must be a power of 2 and at least 4.

Ports:
- `clk` input, 1: clock. The block uses one clock, sampled on the rising edge.
- `rst` input, 1: reset. Asynchronous, active-high.
- `fetch_pkt` input, `If_id_pkt_t[1:0]`: packets from the IFU.
  - Slot 0 is older than slot 1.
  - `fetch_pkt[1].valid` is legal only when `fetch_pkt[0].valid` is 1.
- `flush` input, 1: discard all queued packets.
- `dec_stall` input, 2: per-slot stall from `decode`. `dec_stall[1]` is 1 whenever `dec_stall[0]` is 1.
- `if_id_pkt` output, `If_id_pkt_t[1:0]`: the oldest two queued packets. Slot 0 is the head.
- `fq_stall` output, 1: tells the IFU to hold. The IFU presents no valid packets while it is 1.
- `fq_count` output, `$clog2(DEPTH+1)` bits: current occupancy.

## Operation

**Storage**
- `DEPTH` packet registers.
- `head` and `tail` pointers, `$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`.
- Registered `count`.

**Enqueue**
- `n_enq` is the number of valid `fetch_pkt` slots, 0 to 2. It is forced to 0 when `fq_stall` or `flush` is 1.
- `fetch_pkt[0]` is written at `tail`; `fetch_pkt[1]` at `tail+1` (mod `DEPTH`).
- `tail` advances by `n_enq`.

**Output**
- `if_id_pkt[0]` is the entry at `head` when `count` ≥ 1.
- `if_id_pkt[1]` is the entry at `head+1` when `count` ≥ 2.
- Any slot not backed by an entry drives all fields 0, including `valid`=0.

**Dequeue**
- `n_deq` is computed as follows:
  - 0 if `if_id_pkt[0].valid`=0 or `dec_stall[0]`=1.
  - Otherwise 1 if `if_id_pkt[1].valid`=0 or `dec_stall[1]`=1.
  - Otherwise 2.
- `head` advances by `n_deq`.

**Count**
- Next `count` = `count` + `n_enq` − `n_deq`.
- It never exceeds `DEPTH` and never underflows. Either condition is an assertion failure.

**Full rule**
- `fq_stall` = (`count` > `DEPTH`−2).
- It is computed from the registered `count` only. No credit is given for a dequeue in the same cycle.

**Flush**
- On the next edge, `head`, `tail` and `count` become 0.
- All outputs then show `valid`=0.
- Enqueue and dequeue in the flush cycle are discarded. Flush wins over both.
- Packet storage contents are not cleared. The pointers alone define validity.

**Reset**
- Asynchronous clear of `head`, `tail` and `count` to 0.
- Outputs immediately show `if_id_pkt[*].valid`=0, `fq_stall`=0, `fq_count`=0.
- Storage registers also reset to 0.

**Ordering**
- Packets leave in exactly the order they entered, including across wrap-around.
- Packet fields (`pc`, `npc`, `inst`, `bp_state`, `bp_hit`) pass through unmodified.

## Timing

**Latency**
- A packet enqueued at edge N is visible on `if_id_pkt` after edge N. There is no same-cycle bypass from `fetch_pkt` to `if_id_pkt`; minimum latency is 1 cycle.

**Output paths**
- `if_id_pkt` is a mux of registered storage indexed by registered `head` and `count`. It does not depend on `dec_stall` or `fetch_pkt` within the cycle.
- `fq_stall` and `fq_count` are pure functions of registered `count`.

**Throughput**
- Sustained 2 in / 2 out per cycle with no bubbles when `DEPTH` ≥ 4.

**Simultaneous events**
- Enqueue plus dequeue at `count`=`DEPTH`−2: `fq_stall` is 0, so the enqueue proceeds and count ends at or below `DEPTH`.
- A partial dequeue (`n_deq`=1) shifts the remaining head entry into slot 0 on the next cycle.

**Mid-operation events**
- A reset asserted while the queue is full empties it asynchronously.
- After reset deasserts, the first enqueue is accepted on the first clock edge.

## Test plan

- **Reset:** assert `rst` with the queue holding 5 entries. Required: `if_id_pkt[0].valid`=0, `if_id_pkt[1].valid`=0 and `fq_count`=0 immediately, before any clock edge.
- **Basic pass-through:** enqueue pc=0x0100/0x0102 with `dec_stall`=0. Required: 1 cycle later `if_id_pkt` shows 0x0100/0x0102 with `valid`=2'b11. The following cycle `fq_count`=0.
- **Partial consume:** queue holds 0x10, 0x12, 0x14 and `dec_stall`=2'b10. Required: next cycle slot0=0x12, slot1=0x14, `fq_count`=2.
- **Full / wrap-around:** `DEPTH`=8, `dec_stall`=2'b11, enqueue 2 per cycle. Required:
  - `fq_stall`=1 once `fq_count`=7 or 8.
  - Then release `dec_stall`: 20 sequential pcs drain in order across ≥2 pointer wraps with no loss or duplication.
- **Flush collision:** `flush`=1 in the same cycle as `fetch_pkt` valid=2'b11 and `dec_stall`=0 with `fq_count`=4. Required: next cycle `fq_count`=0, outputs invalid, and the flushed-cycle packets never appear.
- **Single-slot fetch:** alternate `fetch_pkt` valid=2'b01 and 2'b11 for 10 cycles with random `dec_stall` (prefix-legal). Required: a scoreboard sees exact in-order delivery and `fq_count` matches the model every cycle.
